// File: rtl/psum_wb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : psum_wb_ctrl_pkg
//  Purpose : Shared sizing constants and FSM state encoding for the
//            partial-sum write-back sequencer and its address generator.
//  Ports   : (package, no ports)
//  Revision: 1.0 - initial release
// ============================================================================
package psum_wb_ctrl_pkg;

  localparam int unsigned PE_COL      = 32;  // psum banks / PE columns
  localparam int unsigned BIT_ADDR    = 8;   // psum SRAM address width per bank
  localparam int unsigned BIT_PSUM    = 16;  // psum data width on the write-back path
  localparam int unsigned WB_LAT      = 3;   // issue beat -> datapath valid latency

  localparam int unsigned BIT_COL     = $clog2(PE_COL);     // column counter width
  localparam int unsigned BIT_COL_NUM = 6;                  // i_Col_Num width
  localparam int unsigned BIT_ROW_NUM = BIT_ADDR + 1;       // i_Row_Num width
  localparam int unsigned BIT_DRAIN   = $clog2(WB_LAT + 1); // drain counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/psum_wb_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module  : psum_wb_addr_gen
//  Purpose : Column-major column/row counter pair for the psum write-back
//            walk. Row advances every issued beat and wraps into the next
//            column after the last row. Also decodes the column into a
//            one-hot bank select and flags the final beat of the job.
//  Ports   : clk_i, rst_i      clock / async active-high reset
//            clr_i             zero both counters (job start)
//            adv_i             advance by one beat
//            col_num_i         latched number of columns (1..PE_COL)
//            row_num_i         latched rows per column (1..2^BIT_ADDR)
//            row_o             current row (bank read address)
//            onehot_o          one-hot decode of current column
//            last_o            current position is the job's final beat
//  Revision: 1.0 - initial release
// ============================================================================
module psum_wb_addr_gen
  import psum_wb_ctrl_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   adv_i,
  input  logic [BIT_COL_NUM-1:0] col_num_i,
  input  logic [BIT_ROW_NUM-1:0] row_num_i,
  output logic [BIT_ADDR-1:0]    row_o,
  output logic [PE_COL-1:0]      onehot_o,
  output logic                   last_o
);

  logic [BIT_COL-1:0]  col_q, col_d;
  logic [BIT_ADDR-1:0] row_q, row_d;
  logic                w_row_wrap;
  logic                w_col_last;

  // Row counter is one bit narrower than row_num, so widen before comparing
  // (row_num may be exactly 2^BIT_ADDR).
  assign w_row_wrap = (BIT_ROW_NUM'(row_q) == (row_num_i - BIT_ROW_NUM'(1)));
  assign w_col_last = (BIT_COL_NUM'(col_q) == (col_num_i - BIT_COL_NUM'(1)));
  assign last_o     = w_row_wrap && w_col_last;

  assign row_o      = row_q;
  assign onehot_o   = {{(PE_COL-1){1'b0}}, 1'b1} << col_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (w_row_wrap) begin
        // On the final beat this steps past the last column; harmless,
        // the next accepted start clears it.
        row_d = '0;
        col_d = col_q + BIT_COL'(1);
      end else begin
        row_d = row_q + BIT_ADDR'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/psum_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : psum_wb_ctrl
//  Purpose : Partial-sum write-back sequencer. Walks psum banks column-major,
//            one address per ready cycle, driving one-hot bank enable, read
//            address and issue valid into the write-back datapath; waits out
//            the datapath latency and pulses o_Done on its final beat.
//  Ports   : CLK, RST          clock / async active-high reset
//            i_Start           start pulse (IDLE only)
//            i_Col_Num         banks to drain, 1..PE_COL
//            i_Row_Num         entries per bank, 1..2^BIT_ADDR
//            i_WB_Ready        downstream accepts an issue beat this cycle
//            o_Psram_En        one-hot bank select, zero when not issuing
//            o_Psram_Addr      bank read address
//            o_Valid_WB_Psum   issue-beat valid
//            o_Busy            job in progress
//            o_Done            one-cycle completion pulse
//            o_Err             one-cycle illegal-configuration pulse
//  Revision: 1.0 - initial release
// ============================================================================
module psum_wb_ctrl
  import psum_wb_ctrl_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_Start,
  input  logic [BIT_COL_NUM-1:0] i_Col_Num,
  input  logic [BIT_ROW_NUM-1:0] i_Row_Num,
  input  logic                   i_WB_Ready,
  output logic [PE_COL-1:0]      o_Psram_En,
  output logic [BIT_ADDR-1:0]    o_Psram_Addr,
  output logic                   o_Valid_WB_Psum,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Err
);

  localparam logic [BIT_COL_NUM-1:0] C_COL_MAX = BIT_COL_NUM'(PE_COL);
  localparam logic [BIT_ROW_NUM-1:0] C_ROW_MAX = BIT_ROW_NUM'(1 << BIT_ADDR);
  localparam logic [BIT_DRAIN-1:0]   C_DRAIN_LOAD = BIT_DRAIN'(WB_LAT - 1);

  state_e                 state_q, state_d;
  logic [BIT_COL_NUM-1:0] col_num_q, col_num_d;
  logic [BIT_ROW_NUM-1:0] row_num_q, row_num_d;
  logic [BIT_DRAIN-1:0]   drain_q, drain_d;
  logic [PE_COL-1:0]      en_q, en_d;
  logic [BIT_ADDR-1:0]    addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   w_cfg_bad;
  logic                   w_clr;
  logic                   w_adv;
  logic [BIT_ADDR-1:0]    w_row;
  logic [PE_COL-1:0]      w_onehot;
  logic                   w_last;

  // Row counts above 2^BIT_ADDR cannot be addressed and are rejected too.
  assign w_cfg_bad = (i_Col_Num == '0) || (i_Col_Num > C_COL_MAX) ||
                     (i_Row_Num == '0) || (i_Row_Num > C_ROW_MAX);

  psum_wb_addr_gen u_addr_gen (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (w_clr),
    .adv_i     (w_adv),
    .col_num_i (col_num_q),
    .row_num_i (row_num_q),
    .row_o     (w_row),
    .onehot_o  (w_onehot),
    .last_o    (w_last)
  );

  always_comb begin
    state_d   = state_q;
    col_num_d = col_num_q;
    row_num_d = row_num_q;
    drain_d   = drain_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    en_d      = '0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    w_clr     = 1'b0;
    w_adv     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          if (w_cfg_bad) begin
            err_d = 1'b1;
          end else begin
            col_num_d = i_Col_Num;
            row_num_d = i_Row_Num;
            w_clr     = 1'b1;
            busy_d    = 1'b1;
            state_d   = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        // A stall drops valid/enable but keeps the last address on the bus.
        if (i_WB_Ready) begin
          valid_d = 1'b1;
          en_d    = w_onehot;
          addr_d  = w_row;
          w_adv   = 1'b1;
          if (w_last) begin
            drain_d = C_DRAIN_LOAD;
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // Counter hits zero on the cycle the datapath emits the last beat.
        if (drain_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q - BIT_DRAIN'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      col_num_q <= '0;
      row_num_q <= '0;
      drain_q   <= '0;
      en_q      <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_num_q <= col_num_d;
      row_num_q <= row_num_d;
      drain_q   <= drain_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_Psram_En      = en_q;
  assign o_Psram_Addr    = addr_q;
  assign o_Valid_WB_Psum = valid_q;
  assign o_Busy          = busy_q;
  assign o_Done          = done_q;
  assign o_Err           = err_q;

endmodule
`default_nettype wire
